echo_ranger: RTL and testbench
==============================

# echo_ranger

Parametrised ultrasonic ranging engine: on request it emits a trigger pulse of programmable length, then waits for the sensor ECHO rising edge with a timeout. It measures the ECHO high time in CLKOUT cycles, saturating the count, and then enforces a sensor recovery hold-off. It sits between the sensor pins and the distance-calculation logic, and supports single-shot and continuous modes. The result is latched with a one-cycle `calculate` strobe and status flags.

## Interface
- WIDTH, 16: width of the echo-width counter and `count` output.
- TRIG_CYCLES, 10: trigger pulse length in CLKOUT cycles; must be ≥1.
- TIMEOUT_CYCLES, 1000: maximum cycles spent waiting for an ECHO rising edge; must be ≥1.
- HOLDOFF_CYCLES, 50: recovery cycles after each measurement before a new trigger; 0 is allowed.

Ports:
- CLKOUT  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ENABLE  in  1  single-shot start request; sampled only in IDLE.
- CONT  in  1  continuous mode; while 1, the block re-triggers automatically.
- ECHO  in  1  raw sensor echo, asynchronous; passes through a 2-flop synchroniser (`echo_s`).
- pulse  out  1  registered trigger output to the sensor.
- count  out  WIDTH  latched echo width of the last completed measurement.
- calculate  out  1  one-cycle strobe: `count` and the flags have just been updated.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  last measurement saw no echo edge within TIMEOUT_CYCLES.
- overflow  out  1  last measurement saturated the width counter.

## Operation
States:
- IDLE: `pulse`=0, `busy`=0. Leaves when ENABLE=1 or CONT=1, going to TRIG.
- TRIG: `pulse`=1 for exactly TRIG_CYCLES cycles, then goes to WAIT_ECHO. The wait counter clears on entry.
- WAIT_ECHO: looks for a rising edge of `echo_s`, i.e. 0 in the previous cycle and 1 now.
  - If `echo_s` is already high on entry, that stale echo is ignored; the block waits for it to go low and then high.
  - Every cycle counts toward the timeout.
  - On a rising edge: go to MEASURE with the width counter set to 1.
  - When the wait count reaches TIMEOUT_CYCLES: `count`←0, `timeout`←1, `overflow`←0, pulse `calculate`, go to HOLDOFF.
- MEASURE: the width counter increments each cycle `echo_s`=1.
  - On `echo_s`=0: `count`←width, `timeout`←0, `overflow`←0, pulse `calculate`, go to HOLDOFF.
  - If the counter reaches all-ones while `echo_s` is still 1: `count`←all-ones, `overflow`←1, `timeout`←0, pulse `calculate`, go to HOLDOFF. A stuck-high echo never hangs the block.
- HOLDOFF: waits HOLDOFF_CYCLES, with ECHO ignored. Then:
  - CONT=1: go directly to TRIG.
  - otherwise: go to IDLE.
  - With HOLDOFF_CYCLES=0 the block exits on the next edge.

Rules:
- ENABLE is ignored outside IDLE; no request queueing.
- `count`, `timeout` and `overflow` hold their values until the next `calculate`, and change only on the `calculate` cycle.
- Arithmetic:
  - The width counter is unsigned WIDTH bits and never wraps.
  - The wait and hold-off counters are sized with $clog2 of their parameter plus 1.

## Timing
- Reset (async assert, sync-safe deassert) drives: state IDLE, `pulse`=0, `calculate`=0, `busy`=0, `count`=0, `timeout`=0, `overflow`=0, synchroniser flops=0.
- Reset asserted mid-operation aborts the measurement immediately with no `calculate`.
- ENABLE sampled 1 at edge k in IDLE: `pulse` and `busy` are high after edge k. `pulse` goes low after edge k+TRIG_CYCLES.
- ECHO latency: 2 cycles through the synchroniser, applied equally to both edges. A clean ECHO high for H cycles (H < 2^WIDTH−1) yields `count`=H.
- `calculate` asserts on the edge after the one that registers `echo_s` falling, or the terminal timeout/saturation count, and stays high exactly one cycle.
- CONT path: the next `pulse` rises HOLDOFF_CYCLES+1 cycles after `calculate`.
- CONT dropped during a measurement: the current measurement completes, then the block returns to IDLE.

## Test plan
- Reset: hold `reset`=0 with ECHO toggling → every output 0, `busy`=0, and `pulse` never asserts.
- Single shot (defaults): ENABLE one cycle; ECHO high 300 cycles, starting 40 cycles after `pulse` falls → `pulse` high exactly 10 cycles, `count`=300, one `calculate`, `timeout`=0, `overflow`=0, `busy` low 51 cycles after `calculate`.
- Timeout: ENABLE with ECHO held 0 → `calculate` 1000 cycles after entering WAIT_ECHO, `count`=0, `timeout`=1. A following good 120-cycle echo gives `count`=120 and `timeout`=0.
- Saturation: WIDTH=8 with ECHO stuck high after the trigger → `count`=255, `overflow`=1, and the block returns to IDLE after hold-off.
- Stale echo: ECHO already high when TRIG ends, low 5 cycles, then high 77 cycles → `count`=77, not the stale portion.
- Continuous plus corner cases: CONT=1 with echoes of 50 then 60 cycles → two `calculate` strobes, `count` 50 then 60. ENABLE pulsed mid-measure is ignored. Reset asserted during MEASURE → no `calculate`, and all outputs are 0 immediately.

Source files
------------

// File: rtl/echo_ranger_if.sv
// echo_ranger_if: sensor-side and result-side signals of the ranging engine.
interface echo_ranger_if #(
    parameter int WIDTH = 16
);
    logic             ENABLE;
    logic             CONT;
    logic             ECHO;
    logic             pulse;
    logic [WIDTH-1:0] count;
    logic             calculate;
    logic             busy;
    logic             timeout;
    logic             overflow;

    modport slave (
        input  ENABLE, CONT, ECHO,
        output pulse, count, calculate, busy, timeout, overflow
    );

    modport master (
        output ENABLE, CONT, ECHO,
        input  pulse, count, calculate, busy, timeout, overflow
    );
endinterface

// File: rtl/echo_ranger.sv
// echo_ranger: ultrasonic ranging engine -- trigger pulse, echo-edge wait with timeout,
// saturating echo-width measurement and recovery hold-off, single-shot or continuous.
module echo_ranger #(
    parameter int WIDTH          = 16,
    parameter int TRIG_CYCLES    = 10,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int HOLDOFF_CYCLES = 50
) (
    input  logic         CLKOUT,
    input  logic         reset,
    echo_ranger_if.slave bus
);
    localparam int M1   = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
    localparam int MAXC = (M1 > HOLDOFF_CYCLES) ? M1 : HOLDOFF_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [WIDTH-1:0] ONES = '1;

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] width_q, width_d, count_q, count_d;
    logic [1:0]       sync_q;
    logic             echo_prev_q;
    logic             pulse_q, pulse_d, calc_q, calc_d;
    logic             timeout_q, timeout_d, overflow_q, overflow_d;
    logic             echo_s, rise, sat, fin_to, fin_ms;

    assign echo_s = sync_q[1];
    assign rise   = echo_s && !echo_prev_q;
    // Saturate one step early so the counter lands on all-ones and never wraps.
    assign sat    = width_q >= ONES - 1'b1;

    always_ff @(posedge CLKOUT or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            width_q     <= '0;
            sync_q      <= '0;
            echo_prev_q <= 1'b0;
            pulse_q     <= 1'b0;
            calc_q      <= 1'b0;
            count_q     <= '0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            width_q     <= width_d;
            sync_q      <= {sync_q[0], bus.ECHO};
            echo_prev_q <= echo_s;
            pulse_q     <= pulse_d;
            calc_q      <= calc_d;
            count_q     <= count_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        width_d = width_q;
        case (state_q)
            IDLE:      state_d = (bus.ENABLE || bus.CONT) ? TRIG : IDLE;
            TRIG:      state_d = (cnt_q == CW'(TRIG_CYCLES - 1)) ? WAIT_ECHO : TRIG;
            WAIT_ECHO: begin
                state_d = rise ? MEASURE : (cnt_q == CW'(TIMEOUT_CYCLES - 1)) ? HOLDOFF : WAIT_ECHO;
                width_d = WIDTH'(1);
            end
            MEASURE:   begin
                state_d = (!echo_s || sat) ? HOLDOFF : MEASURE;
                width_d = sat ? ONES : width_q + 1'b1;
            end
            HOLDOFF:   state_d = (cnt_q == CW'(HOLDOFF_CYCLES)) ? (bus.CONT ? TRIG : IDLE) : HOLDOFF;
            default:   state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        fin_to     = (state_q == WAIT_ECHO) && (state_d == HOLDOFF);
        fin_ms     = (state_q == MEASURE) && (state_d == HOLDOFF);
        calc_d     = fin_to || fin_ms;
        pulse_d    = state_d == TRIG;
        count_d    = fin_to ? '0 : fin_ms ? (echo_s ? ONES : width_q) : count_q;
        timeout_d  = calc_d ? fin_to : timeout_q;
        overflow_d = calc_d ? (fin_ms && echo_s) : overflow_q;
    end

    assign bus.pulse     = pulse_q;
    assign bus.calculate = calc_q;
    assign bus.count     = count_q;
    assign bus.timeout   = timeout_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_echo_ranger.sv
// tb_echo_ranger: random and directed ranging runs checked against a transaction-level
// model of echo width, timeout, saturation and hold-off timing.
module tb_echo_ranger;
    localparam int TRIG = 10;
    localparam int TMO  = 1000;
    localparam int HOLD = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    echo_ranger_if #(.WIDTH(16)) a();
    echo_ranger_if #(.WIDTH(8))  b();

    echo_ranger #(.WIDTH(16), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO), .HOLDOFF_CYCLES(HOLD))
        u_dut (.CLKOUT(clk), .reset(rst_n), .bus(a));
    echo_ranger #(.WIDTH(8), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO), .HOLDOFF_CYCLES(HOLD))
        u_sat (.CLKOUT(clk), .reset(rst_n), .bus(b));

    int n_chk = 0, n_fail = 0, cyc = 0;
    int rise_cyc, fall_cyc, calc_cyc, bfall_cyc, n_rise = 0, n_fall = 0, n_calc = 0, n_bfall = 0;
    int b_fall_n = 0, b_calc_cyc, b_n_calc = 0, b_bfall_cyc, b_n_bfall = 0;
    logic prev_pulse = 0, prev_calc = 0, prev_busy = 0, b_prev_pulse = 0, b_prev_busy = 0;
    logic [15:0] exp_count = 0, pend_count = 0;
    logic exp_to = 0, exp_ov = 0, pend_to = 0, pend_ov = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Samples both DUTs once per cycle on the falling edge and keeps the result model current.
    task tick();
        @(negedge clk);
        cyc++;
        if (a.pulse && !prev_pulse) begin rise_cyc = cyc; n_rise++; end
        if (!a.pulse && prev_pulse) begin fall_cyc = cyc; n_fall++; end
        if (!a.busy && prev_busy) begin bfall_cyc = cyc; n_bfall++; end
        if (a.calculate) begin
            chk("calc_one_cycle", 32'(prev_calc), 0);
            n_calc++;
            calc_cyc  = cyc;
            exp_count = pend_count;
            exp_to    = pend_to;
            exp_ov    = pend_ov;
        end
        if (rst_n) chk("result_hold", {a.count, a.timeout, a.overflow}, {exp_count, exp_to, exp_ov});
        if (!b.pulse && b_prev_pulse) b_fall_n++;
        if (b.calculate) begin b_n_calc++; b_calc_cyc = cyc; end
        if (!b.busy && b_prev_busy) begin b_bfall_cyc = cyc; b_n_bfall++; end
        prev_pulse   = a.pulse;
        prev_calc    = a.calculate;
        prev_busy    = a.busy;
        b_prev_pulse = b.pulse;
        b_prev_busy  = b.busy;
    endtask

    function automatic int ev(input int w);
        case (w)
            0: return n_fall;
            1: return n_calc;
            2: return n_bfall;
            3: return b_fall_n;
            4: return b_n_calc;
            default: return b_n_bfall;
        endcase
    endfunction

    task automatic wait_ev(input int w, input int lim, input string tag);
        int base = ev(w);
        int t = 0;
        while (ev(w) == base && t < lim) begin tick(); t++; end
        if (ev(w) == base) chk({tag, "_expired"}, 0, 1);
    endtask

    task automatic fire();
        int s;
        a.ENABLE = 1'b1;
        s = cyc;
        tick();
        a.ENABLE = 1'b0;
        chk("pulse_rise", rise_cyc - s, 1);
    endtask

    // mode 1: pulse ENABLE mid-echo; mode 2: drop CONT mid-echo.
    task automatic do_shot(input int d, input int h, input int mode);
        int e;
        wait_ev(0, 200, "pulse_fall");
        chk("pulse_width", fall_cyc - rise_cyc, TRIG);
        repeat (d) tick();
        a.ECHO = 1'b1;
        e = cyc;
        pend_count = 16'(h); pend_to = 0; pend_ov = 0;
        for (int i = 0; i < h; i++) begin
            if (i == h / 2 && mode == 1) a.ENABLE = 1'b1;
            if (i == h / 2 && mode == 2) a.CONT = 1'b0;
            tick();
            a.ENABLE = 1'b0;
        end
        a.ECHO = 1'b0;
        wait_ev(1, 20, "calc");
        chk("calc_latency", calc_cyc - e, h + 3);
        chk("count", a.count, h);
    endtask

    task automatic to_shot();
        fire();
        wait_ev(0, 200, "pulse_fall");
        pend_count = 0; pend_to = 1; pend_ov = 0;
        wait_ev(1, TMO + 100, "timeout_calc");
        chk("timeout_latency", calc_cyc - fall_cyc, TMO);
        chk("timeout_flag", 32'(a.timeout), 1);
    endtask

    task automatic wait_idle();
        wait_ev(2, HOLD + 20, "busy_fall");
        chk("holdoff", bfall_cyc - calc_cyc, HOLD + 1);
    endtask

    initial begin
        int nr, nc, c1, e;
        a.ENABLE = 0; a.CONT = 0; a.ECHO = 0;
        b.ENABLE = 0; b.CONT = 0; b.ECHO = 0;
        // Reset held with activity on the inputs
        for (int i = 0; i < 20; i++) begin
            a.ECHO = 1'($urandom);
            a.ENABLE = 1'b1;
            tick();
            chk("reset_outs", {a.pulse, a.busy, a.calculate, a.timeout, a.overflow, a.count}, 0);
        end
        a.ENABLE = 0; a.ECHO = 0;
        rst_n = 1'b1;
        repeat (4) tick();

        // Directed single shot, with an ignored ENABLE mid-measure
        fire();
        do_shot(40, 300, 1);
        chk("timeout_clear", 32'(a.timeout), 0);
        wait_idle();
        nr = n_rise;
        repeat (10) tick();
        chk("enable_ignored", n_rise, nr);
        chk("idle_busy", 32'(a.busy), 0);

        // Timeout then a good echo
        to_shot();
        wait_idle();
        fire();
        do_shot(5, 120, 0);
        chk("after_to_flag", 32'(a.timeout), 0);
        wait_idle();

        // Random single shots and timeouts
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) to_shot();
            else begin
                fire();
                do_shot(int'($urandom_range(0, 300)), int'($urandom_range(1, 1500)), 0);
            end
            wait_idle();
        end

        // Stale echo already high when the trigger ends
        a.ECHO = 1'b1;
        repeat (3) tick();
        fire();
        wait_ev(0, 200, "stale_fall");
        repeat (3) tick();
        a.ECHO = 1'b0;
        repeat (5) tick();
        a.ECHO = 1'b1;
        e = cyc;
        pend_count = 77; pend_to = 0; pend_ov = 0;
        repeat (77) tick();
        a.ECHO = 1'b0;
        wait_ev(1, 20, "stale_calc");
        chk("stale_count", a.count, 77);
        chk("stale_latency", calc_cyc - e, 80);
        wait_idle();

        // Continuous mode, CONT dropped during the second measurement
        nc = n_calc;
        a.CONT = 1'b1;
        tick();
        do_shot(10, 50, 0);
        c1 = calc_cyc;
        do_shot(20, 60, 2);
        chk("cont_retrigger", rise_cyc - c1, HOLD + 1);
        wait_idle();
        chk("cont_calcs", n_calc - nc, 2);
        repeat (5) tick();
        chk("cont_stopped", 32'(a.busy), 0);

        // Reset in the middle of MEASURE
        fire();
        wait_ev(0, 200, "rst_fall");
        repeat (5) tick();
        a.ECHO = 1'b1;
        repeat (20) tick();
        nc = n_calc;
        #2 rst_n = 1'b0;
        #1 chk("rst_abort", {a.pulse, a.busy, a.calculate, a.timeout, a.overflow, a.count}, 0);
        exp_count = 0; exp_to = 0; exp_ov = 0;
        repeat (5) tick();
        a.ECHO = 1'b0;
        chk("rst_no_calc", n_calc, nc);
        rst_n = 1'b1;
        repeat (4) tick();

        // Saturation on the 8-bit instance with ECHO stuck high
        b.ENABLE = 1'b1;
        tick();
        b.ENABLE = 1'b0;
        wait_ev(3, 200, "sat_fall");
        b.ECHO = 1'b1;
        e = cyc;
        wait_ev(4, 400, "sat_calc");
        chk("sat_count", b.count, 255);
        chk("sat_overflow", 32'(b.overflow), 1);
        chk("sat_timeout", 32'(b.timeout), 0);
        chk("sat_latency", b_calc_cyc - e, 2 + 255);
        wait_ev(5, HOLD + 20, "sat_idle");
        chk("sat_holdoff", b_bfall_cyc - b_calc_cyc, HOLD + 1);
        repeat (10) tick();
        chk("sat_stays_idle", 32'(b.busy), 0);
        b.ECHO = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
